// File: rtl/sequenciador_cp_if.sv
// Bundle of control strobes, targets and status between the control unit and the
// program-counter sequencer. The master side drives strobes; the slave side is the sequencer.
interface sequenciador_cp_if #(
    parameter int ADDR_WIDTH  = 9,
    parameter int STACK_DEPTH = 8
);
    logic                             Jump;
    logic                             Branch;
    logic                             BranchNE;
    logic                             zero;
    logic                             Jal;
    logic                             Jr;
    logic                             OpHalt;
    logic                             stall;
    logic                             resume;
    logic [ADDR_WIDTH-1:0]            desvio;
    logic [ADDR_WIDTH-1:0]            leitura1;
    logic [ADDR_WIDTH-1:0]            end_instrucao;
    logic [ADDR_WIDTH-1:0]            end_retorno;
    logic                             halted;
    logic                             falha;
    logic                             pilha_vazia;
    logic                             pilha_cheia;
    logic [$clog2(STACK_DEPTH):0]     profundidade;

    modport master (
        output Jump, Branch, BranchNE, zero, Jal, Jr, OpHalt, stall, resume, desvio, leitura1,
        input  end_instrucao, end_retorno, halted, falha, pilha_vazia, pilha_cheia, profundidade
    );

    modport slave (
        input  Jump, Branch, BranchNE, zero, Jal, Jr, OpHalt, stall, resume, desvio, leitura1,
        output end_instrucao, end_retorno, halted, falha, pilha_vazia, pilha_cheia, profundidade
    );
endinterface

// File: rtl/sequenciador_cp.sv
// Program-counter sequencer: prioritised next-address selection, optional return-address
// stack for Jal/Jr, halt/resume handling and a sticky stack-fault state.
module sequenciador_cp #(
    parameter int ADDR_WIDTH  = 9,
    parameter int STACK_DEPTH = 8,
    parameter int RETURN_MODE = 1,
    parameter int RESET_ADDR  = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    sequenciador_cp_if.slave     bus
);
    localparam int PW = $clog2(STACK_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push_en;
    logic [ADDR_WIDTH-1:0] pc_plus1;
    logic [PW-1:0]         top_idx;
    logic [PW-1:0]         push_idx;
    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

    assign pc_plus1 = pc_q + ADDR_WIDTH'(1);
    assign push_idx = count_q[PW-1:0];
    assign top_idx  = count_q[PW-1:0] - PW'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            pc_q    <= ADDR_WIDTH'(RESET_ADDR);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    // Stack contents need no reset; only the count defines which entries are valid.
    always_ff @(posedge clock) begin
        if (push_en)
            stack_mem[push_idx] <= pc_plus1;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        push_en = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!bus.stall) begin
                    if (bus.OpHalt) begin
                        state_d = ST_HALT;
                    end else if (bus.Jr) begin
                        if (RETURN_MODE == 0) begin
                            pc_d = bus.leitura1;
                        end else if (count_q == '0) begin
                            state_d = ST_FAULT;
                        end else begin
                            pc_d    = stack_mem[top_idx];
                            count_d = count_q - CW'(1);
                        end
                    end else if (bus.Jal) begin
                        if (RETURN_MODE == 0) begin
                            pc_d = bus.desvio;
                        end else if (count_q == CW'(STACK_DEPTH)) begin
                            state_d = ST_FAULT;
                        end else begin
                            pc_d    = bus.desvio;
                            push_en = 1'b1;
                            count_d = count_q + CW'(1);
                        end
                    end else if (bus.Jump) begin
                        pc_d = bus.desvio;
                    end else if (bus.Branch && bus.zero) begin
                        pc_d = bus.desvio;
                    end else if (bus.BranchNE && !bus.zero) begin
                        pc_d = bus.desvio;
                    end else begin
                        pc_d = pc_plus1;
                    end
                end
            end
            ST_HALT: begin
                if (bus.resume) begin
                    pc_d    = pc_plus1;
                    state_d = ST_RUN;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.end_instrucao = pc_q;
    assign bus.end_retorno   = pc_plus1;
    assign bus.halted        = (state_q == ST_HALT);
    assign bus.falha         = (state_q == ST_FAULT);
    assign bus.pilha_vazia   = (count_q == '0);
    assign bus.pilha_cheia   = (count_q == CW'(STACK_DEPTH));
    assign bus.profundidade  = count_q;
endmodule
